picture_capture: RTL and testbench

- Writer-side counterpart of the on-screen picture blobs: captures a WIDTH x HEIGHT window of the live 24-bit pixel stream into an 8-bit image RAM.
- The display path later reads that RAM back.
- Sits between the video/camera pixel source, which supplies hcount, vcount and pixel, and a single-port write interface of a block RAM.
- Stores RGB332 at column-major addresses: addr = (vcount-y) + (hcount-x)*HEIGHT, the same layout the display readers use.

---
 rtl/picture_capture_pkg.sv | 20 ++
 rtl/picture_capture_addr.sv | 47 ++++
 rtl/picture_capture.sv | 123 ++++++++++++
 tb/tb_picture_capture.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picture_capture_pkg.sv
// Shared types and helpers for the picture capture writer: FSM encoding,
// default window geometry and the RGB332 packing used by the image RAM.
package picture_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2
   } state_e;

   localparam int DEF_WIDTH      = 100;
   localparam int DEF_HEIGHT     = 77;
   localparam int DEF_ADDR_WIDTH = 13;

   // {R[7:5], G[7:5], B[7:6]}
   function automatic logic [7:0] rgb332(input logic [23:0] p);
      return {p[23:21], p[15:13], p[7:6]};
   endfunction

endpackage

// File: rtl/picture_capture_addr.sv
// Window hit test and column-major RAM address for the capture writer.
// The address register only loads on accepted pixels and holds otherwise.
module picture_capture_addr #(
   parameter int WIDTH      = 100,
   parameter int HEIGHT     = 77,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [10:0]           hcount,
   input  logic [9:0]            vcount,
   input  logic [10:0]           xl,
   input  logic [9:0]            yl,
   output logic                  in_window,
   output logic [ADDR_WIDTH-1:0] waddr
);

   logic [11:0]           x_end;
   logic [10:0]           y_end;
   logic [10:0]           col;
   logic [9:0]            row;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [ADDR_WIDTH-1:0] waddr_d;

   // One extra bit on the upper bounds so a window near the raster edge cannot wrap
   assign x_end = {1'b0, xl} + 12'(WIDTH);
   assign y_end = {1'b0, yl} + 11'(HEIGHT);

   assign in_window = (hcount >= xl) && ({1'b0, hcount} < x_end) &&
                      (vcount >= yl) && ({1'b0, vcount} < y_end);

   assign col     = hcount - xl;
   assign row     = vcount - yl;
   assign waddr_d = ADDR_WIDTH'(32'(row) + 32'(col) * 32'(HEIGHT));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         waddr_q <= '0;
      end else if (load) begin
         waddr_q <= waddr_d;
      end
   end

   assign waddr = waddr_q;

endmodule

// File: rtl/picture_capture.sv
// Captures a WIDTH x HEIGHT window of the live pixel stream into an 8-bit
// image RAM, one full frame per start request, column-major RGB332.
module picture_capture
   import picture_capture_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int HEIGHT     = DEF_HEIGHT,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [10:0]           x,
   input  logic [9:0]            y,
   input  logic [10:0]           hcount,
   input  logic [9:0]            vcount,
   input  logic                  pixel_valid,
   input  logic [23:0]           pixel_in,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [7:0]            wdata,
   output logic                  busy,
   output logic                  done
);

   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CW    = $clog2(TOTAL + 1);

   state_e          state_q, state_d;
   logic [10:0]     xl_q, xl_d;
   logic [9:0]      yl_q, yl_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q;
   logic            done_q, done_d;
   logic [7:0]      wdata_q;
   logic            accept;
   logic            in_window;
   logic            origin;
   logic            hit;

   picture_capture_addr #(
      .WIDTH      (WIDTH),
      .HEIGHT     (HEIGHT),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr (
      .clock     (clock),
      .reset     (reset),
      .load      (accept),
      .hcount    (hcount),
      .vcount    (vcount),
      .xl        (xl_q),
      .yl        (yl_q),
      .in_window (in_window),
      .waddr     (waddr)
   );

   assign origin = pixel_valid && (hcount == 11'd0) && (vcount == 10'd0);
   assign hit    = pixel_valid && in_window;

   always_comb begin
      state_d = state_q;
      xl_d    = xl_q;
      yl_d    = yl_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ARMED;
               xl_d    = x;
               yl_d    = y;
               cnt_d   = '0;
            end
         end
         ARMED: begin
            if (origin) begin
               state_d = CAPTURE;
               accept  = hit;
               cnt_d   = CW'(hit);
            end
         end
         CAPTURE: begin
            // The cycle after the final write is spent here so done and we coincide
            if (cnt_q == CW'(TOTAL)) begin
               state_d = IDLE;
            end else begin
               accept = hit;
               cnt_d  = (origin ? '0 : cnt_q) + CW'(hit);
            end
         end
         default: state_d = IDLE;
      endcase
      done_d = accept && (cnt_d == CW'(TOTAL));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         xl_q    <= '0;
         yl_q    <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         xl_q    <= xl_d;
         yl_q    <= yl_d;
         cnt_q   <= cnt_d;
         we_q    <= accept;
         done_q  <= done_d;
         if (accept) begin
            wdata_q <= rgb332(pixel_in);
         end
      end
   end

   assign we    = we_q;
   assign wdata = wdata_q;
   assign done  = done_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_picture_capture.sv
// Scoreboard bench for picture_capture: a 4x3 instance and a default 100x77
// instance share one pixel stream; expected writes are queued as pixels are driven.
module tb_picture_capture;

   logic        clock       = 1'b0;
   logic        reset       = 1'b1;
   logic        start_s     = 1'b0;
   logic        start_b     = 1'b0;
   logic [10:0] x           = 11'd10;
   logic [9:0]  y           = 10'd5;
   logic [10:0] hcount      = '0;
   logic [9:0]  vcount      = '0;
   logic        pixel_valid = 1'b0;
   logic [23:0] pixel_in    = '0;

   logic        we_s, busy_s, done_s;
   logic [3:0]  waddr_s;
   logic [7:0]  wdata_s;
   logic        we_b, busy_b, done_b;
   logic [12:0] waddr_b;
   logic [7:0]  wdata_b;

   typedef struct {
      int addr;
      int data;
      bit last;
   } exp_t;

   exp_t q_s[$];
   exp_t q_b[$];

   int n_checks = 0;
   int n_errors = 0;
   int m_st[2];
   int m_xl[2];
   int m_yl[2];
   int m_cnt[2];
   int m_w[2] = '{4, 100};
   int m_h[2] = '{3, 77};
   int n_wr[2];
   int n_done[2];
   int last_addr[2];
   bit color_chk = 1'b0;
   int rst_at    = 0;

   picture_capture #(.WIDTH(4), .HEIGHT(3), .ADDR_WIDTH(4)) u_small (
      .clock(clock), .reset(reset), .start(start_s), .x(x), .y(y),
      .hcount(hcount), .vcount(vcount), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
      .we(we_s), .waddr(waddr_s), .wdata(wdata_s), .busy(busy_s), .done(done_s)
   );

   picture_capture u_big (
      .clock(clock), .reset(reset), .start(start_b), .x(x), .y(y),
      .hcount(hcount), .vcount(vcount), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
      .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .busy(busy_b), .done(done_b)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   function automatic int ref_rgb(input logic [23:0] p);
      logic [7:0] r;
      r = {p[23:21], p[15:13], p[7:6]};
      return int'(r);
   endfunction

   task automatic model(input int d, input bit s, input bit valid, input int h, input int v,
                        input logic [23:0] pix);
      bit   origin, inwin, take;
      exp_t e;
      origin = valid && h == 0 && v == 0;
      inwin  = valid && h >= m_xl[d] && h < m_xl[d] + m_w[d] &&
               v >= m_yl[d] && v < m_yl[d] + m_h[d];
      take   = 1'b0;
      case (m_st[d])
         0: if (s) begin
            m_st[d]  = 1;
            m_xl[d]  = int'(x);
            m_yl[d]  = int'(y);
            m_cnt[d] = 0;
         end
         1: if (origin) begin
            m_st[d]  = 2;
            m_cnt[d] = 0;
            take     = 1'b1;
         end
         2: begin
            if (origin) m_cnt[d] = 0;
            take = 1'b1;
         end
         default: m_st[d] = 0;
      endcase
      if (take && inwin) begin
         m_cnt[d]++;
         e.addr = (v - m_yl[d]) + (h - m_xl[d]) * m_h[d];
         e.data = ref_rgb(pix);
         e.last = (m_cnt[d] == m_w[d] * m_h[d]);
         if (e.last) m_st[d] = 3;
         if (d == 0) q_s.push_back(e);
         else        q_b.push_back(e);
      end
   endtask

   task automatic observe(input int d);
      logic we_v, done_v, busy_v;
      int   addr_v, data_v;
      bit   has;
      exp_t e;
      if (d == 0) begin
         we_v = we_s; done_v = done_s; busy_v = busy_s;
         addr_v = int'(waddr_s); data_v = int'(wdata_s);
         has = (q_s.size() != 0);
         if (has) e = q_s.pop_front();
      end else begin
         we_v = we_b; done_v = done_b; busy_v = busy_b;
         addr_v = int'(waddr_b); data_v = int'(wdata_b);
         has = (q_b.size() != 0);
         if (has) e = q_b.pop_front();
      end
      check($sformatf("we[%0d]", d), int'(we_v), int'(has));
      if (we_v) begin
         n_wr[d]++;
         last_addr[d] = addr_v;
      end
      if (done_v) n_done[d]++;
      if (has) begin
         check($sformatf("waddr[%0d]", d), addr_v, e.addr);
         check($sformatf("wdata[%0d]", d), data_v, e.data);
         check($sformatf("done[%0d]", d), int'(done_v), int'(e.last));
         if (d == 0 && color_chk && e.addr == 0) check("rgb332", data_v, 32'hF1);
      end else begin
         check($sformatf("done_idle[%0d]", d), int'(done_v), 0);
      end
      check($sformatf("busy[%0d]", d), int'(busy_v), int'(m_st[d] != 0));
   endtask

   task automatic cyc(input bit s0, input bit s1, input bit valid, input int h, input int v,
                      input logic [23:0] pix);
      start_s     = s0;
      start_b     = s1;
      pixel_valid = valid;
      hcount      = 11'(h);
      vcount      = 10'(v);
      pixel_in    = pix;
      model(0, s0, valid, h, v, pix);
      model(1, s1, valid, h, v, pix);
      @(posedge clock);
      #1;
      observe(0);
      observe(1);
      start_s = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic mid_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_we", int'(we_b), 0);
      check("rst_busy", int'(busy_b), 0);
      check("rst_done", int'(done_b), 0);
      check("rst_waddr", int'(waddr_b), 0);
      @(posedge clock);
      @(negedge clock) reset = 1'b0;
      m_st = '{0, 0};
      m_cnt = '{0, 0};
      q_s.delete();
      q_b.delete();
   endtask

   task automatic run_rows(input int hn, input int v0, input int v1, input int gap,
                           input bit [1:0] smask, input int sh, input int sv);
      logic [23:0] pix;
      bit          hitp;
      for (int v = v0; v <= v1; v++) begin
         for (int h = 0; h < hn; h++) begin
            while (gap > 0 && int'($urandom_range(99)) < gap)
               cyc(1'b0, 1'b0, 1'b0, h, v, 24'($urandom));
            pix  = (color_chk && h == 10 && v == 5) ? 24'hFF8040 : 24'($urandom);
            hitp = (h == sh && v == sv);
            cyc(smask[0] && hitp, smask[1] && hitp, 1'b1, h, v, pix);
            if (rst_at > 0 && m_st[1] == 2 && m_cnt[1] == rst_at) begin
               mid_reset();
               return;
            end
         end
      end
   endtask

   task automatic clr();
      n_wr   = '{0, 0};
      n_done = '{0, 0};
   endtask

   task automatic expect_stats(input string tag, input int d, input int wr, input int dn);
      check({tag, "_writes"}, n_wr[d], wr);
      check({tag, "_dones"}, n_done[d], dn);
   endtask

   initial begin
      m_st = '{0, 0};
      m_cnt = '{0, 0};
      #1;
      check("reset_we", int'(we_s) + int'(we_b), 0);
      check("reset_waddr", int'(waddr_s) + int'(waddr_b), 0);
      check("reset_wdata", int'(wdata_s) + int'(wdata_b), 0);
      check("reset_busy", int'(busy_s) + int'(busy_b), 0);
      check("reset_done", int'(done_s) + int'(done_b), 0);
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b0;

      // Basic 4x3 capture at (10,5) with the packing pixel at the window origin
      clr();
      color_chk = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 24'h0);
      run_rows(20, 0, 9, 0, 2'b00, -1, -1);
      color_chk = 1'b0;
      expect_stats("basic", 0, 12, 1);
      $display("basic capture: writes=%0d dones=%0d", n_wr[0], n_done[0]);

      // Start late in a frame: the tail is ignored until the next origin
      clr();
      run_rows(320, 200, 201, 0, 2'b01, 300, 200);
      expect_stats("arm_tail", 0, 0, 0);
      run_rows(20, 0, 9, 0, 2'b00, -1, -1);
      expect_stats("arm_tail_next", 0, 12, 1);
      $display("arm at (300,200): writes=%0d dones=%0d", n_wr[0], n_done[0]);

      // Start before the window rows of the current frame
      clr();
      run_rows(20, 0, 9, 0, 2'b01, 2, 3);
      expect_stats("arm_mid", 0, 0, 0);
      run_rows(20, 0, 9, 0, 2'b00, -1, -1);
      expect_stats("arm_mid_next", 0, 12, 1);
      $display("arm at (2,3): writes=%0d dones=%0d", n_wr[0], n_done[0]);

      // 50% valid gaps plus a start pulse mid-capture
      clr();
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 24'h0);
      run_rows(20, 0, 9, 50, 2'b01, 11, 6);
      expect_stats("gaps", 0, 12, 1);
      $display("gaps + ignored start: writes=%0d dones=%0d", n_wr[0], n_done[0]);

      // Truncated frame followed by a fresh origin restarts the count
      clr();
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 24'h0);
      run_rows(20, 0, 6, 0, 2'b00, -1, -1);
      run_rows(20, 0, 9, 0, 2'b00, -1, -1);
      expect_stats("glitch", 0, 20, 1);
      $display("origin glitch restart: writes=%0d dones=%0d", n_wr[0], n_done[0]);

      // Both instances, x moved after start; full default-size capture
      clr();
      x = 11'd10;
      cyc(1'b1, 1'b1, 1'b0, 0, 0, 24'h0);
      x = 11'd50;
      run_rows(112, 0, 83, 0, 2'b00, -1, -1);
      x = 11'd10;
      expect_stats("latched_small", 0, 12, 1);
      expect_stats("full_big", 1, 7700, 1);
      check("full_big_last_addr", last_addr[1], 7699);
      $display("latched/full: small writes=%0d big writes=%0d last=%0d",
               n_wr[0], n_wr[1], last_addr[1]);

      // Asynchronous reset after 500 written pixels, then a clean recapture
      clr();
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 24'h0);
      rst_at = 500;
      run_rows(112, 0, 83, 0, 2'b00, -1, -1);
      rst_at = 0;
      expect_stats("reset_mid", 1, 500, 0);
      clr();
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 24'h0);
      run_rows(112, 0, 83, 0, 2'b00, -1, -1);
      expect_stats("after_reset", 1, 7700, 1);
      $display("recapture after reset: writes=%0d dones=%0d", n_wr[1], n_done[1]);

      check("scoreboard_empty", q_s.size() + q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
